// File: rtl/pattern_gen_pkg.sv
// Shared types and colour constants for the multi-mode video test source.
// Imported by the raster counter and the pattern generator top level.
package pattern_gen_pkg;

   typedef enum logic [1:0] {
      MODE_QUAD  = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_RAMP  = 2'd2,
      MODE_SOLID = 2'd3
   } mode_e;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   localparam logic [23:0] QUAD_Q1 = 24'h00CC00;
   localparam logic [23:0] QUAD_Q2 = 24'h00CCCC;
   localparam logic [23:0] QUAD_Q3 = 24'hFF9A26;
   localparam logic [23:0] QUAD_Q4 = 24'h9D26FF;

   // white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [23:0] BAR_COLOR [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic logic [23:0] rgb(
      input logic [7:0] r,
      input logic [7:0] g,
      input logic [7:0] b
   );
      logic [23:0] c;
      c = '0;
      c[R_HI:R_LO] = r;
      c[G_HI:G_LO] = g;
      c[B_HI:B_LO] = b;
      return c;
   endfunction

endpackage

// File: rtl/pattern_generator_multi_raster_counter.sv
// Raster position counters (x, y, frame) advanced by a strobe.
// Exposes last-pixel, last-line and last-frame flags for reuse downstream.
module raster_counter
   import pattern_gen_pkg::*;
#(
   parameter int WIDTH  = 800,
   parameter int HEIGHT = 600,
   parameter int RATE   = 72,
   parameter int XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
   parameter int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
   parameter int FW     = (RATE > 1) ? $clog2(RATE) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          advance,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last_pix,
   output logic          last_line,
   output logic          last_frame
);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [FW-1:0] f_q, f_d;

   assign last_pix   = (x_q == XW'(WIDTH - 1));
   assign last_line  = (y_q == YW'(HEIGHT - 1));
   assign last_frame = (f_q == FW'(RATE - 1));
   assign x          = x_q;
   assign y          = y_q;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      f_d = f_q;
      if (advance) begin
         if (last_pix) begin
            x_d = '0;
            if (last_line) begin
               y_d = '0;
               f_d = last_frame ? '0 : f_q + FW'(1);
            end else begin
               y_d = y_q + YW'(1);
            end
         end else begin
            x_d = x_q + XW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q <= '0;
         y_q <= '0;
         f_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         f_q <= f_d;
      end
   end

endmodule

// File: rtl/pattern_generator_multi.sv
// Multi-mode raster test source with ready/valid output handshake.
// Mode and inversion only change at frame boundaries.
module pattern_generator_multi
   import pattern_gen_pkg::*;
#(
   parameter int          VISIBLE_WIDTH  = 800,
   parameter int          VISIBLE_HEIGHT = 600,
   parameter int          FRAME_RATE     = 72,
   parameter int          TILE_W_LOG2    = 6,
   parameter int          TILE_H_LOG2    = 5,
   parameter int          BAR_W_LOG2     = 7,
   parameter bit          INVERT_EN      = 1'b1,
   parameter logic [23:0] SOLID_COLOR    = 24'h808080
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  Mode,
   input  logic        VideoReady,
   output logic        VideoValid,
   output logic [23:0] Video,
   output logic        StartOfFrame,
   output logic        EndOfLine
);

   localparam int XW = (VISIBLE_WIDTH > 1) ? $clog2(VISIBLE_WIDTH) : 1;
   localparam int YW = (VISIBLE_HEIGHT > 1) ? $clog2(VISIBLE_HEIGHT) : 1;

   logic          valid_q, valid_d;
   mode_e         mode_q, mode_d;
   logic          inv_q, inv_d;
   logic          accept;
   logic          frame_end;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          last_pix, last_line, last_frame;
   logic          h, v;
   logic [2:0]    bar_idx;
   logic [7:0]    ramp;
   logic [23:0]   base;

   assign accept    = valid_q & VideoReady;
   assign frame_end = last_pix & last_line;

   raster_counter #(
      .WIDTH  (VISIBLE_WIDTH),
      .HEIGHT (VISIBLE_HEIGHT),
      .RATE   (FRAME_RATE),
      .XW     (XW),
      .YW     (YW)
   ) u_raster (
      .clock      (clock),
      .reset      (reset),
      .advance    (accept),
      .x          (x),
      .y          (y),
      .last_pix   (last_pix),
      .last_line  (last_line),
      .last_frame (last_frame)
   );

   always_comb begin
      valid_d = 1'b1;
      mode_d  = mode_q;
      inv_d   = inv_q;
      if (accept && frame_end) begin
         mode_d = mode_e'(Mode);
         if (INVERT_EN && last_frame) begin
            inv_d = ~inv_q;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         mode_q  <= mode_e'(Mode);
         inv_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         mode_q  <= mode_d;
         inv_q   <= inv_d;
      end
   end

   // Shift-then-truncate keeps tile/bar bit selects legal for any width.
   assign h       = 1'(x >> TILE_W_LOG2);
   assign v       = 1'(y >> TILE_H_LOG2);
   assign bar_idx = 3'(x >> BAR_W_LOG2);
   assign ramp    = 8'(x);

   always_comb begin
      base = SOLID_COLOR;
      unique case (mode_q)
         MODE_QUAD: begin
            unique case ({v, h})
               2'b00:   base = QUAD_Q1;
               2'b01:   base = QUAD_Q2;
               2'b10:   base = QUAD_Q3;
               default: base = QUAD_Q4;
            endcase
         end
         MODE_BARS:  base = BAR_COLOR[bar_idx];
         MODE_RAMP:  base = rgb(ramp, ramp, ramp);
         MODE_SOLID: base = SOLID_COLOR;
      endcase
   end

   assign VideoValid   = valid_q;
   assign Video        = inv_q ? ~base : base;
   assign StartOfFrame = (x == '0) && (y == '0);
   assign EndOfLine    = last_pix;

endmodule

// File: tb/tb_pattern_generator_multi.sv
// Randomised self-checking bench for pattern_generator_multi.
// Reference model works from the pixel index since the last reset.
module tb_pattern_generator_multi;

   localparam int W    = 300;
   localparam int H    = 4;
   localparam int RATE = 3;
   localparam int TW   = 4;
   localparam int TH   = 1;
   localparam int BW   = 3;
   localparam int FP   = W * H;
   localparam logic [23:0] SOLID = 24'h808080;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mode  = 2'd0;
   logic        ready = 1'b0;
   logic        valid_a, valid_b;
   logic [23:0] video_a, video_b;
   logic        sof_a, sof_b, eol_a, eol_b;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   int unsigned n        = 0;
   logic [1:0]  mmode    = 2'd0;
   logic        mvalid   = 1'b0;
   bit          scripted = 1'b0;
   bit          have_sof = 1'b0;
   int unsigned sof_n    = 0;

   always #5 clock = ~clock;

   pattern_generator_multi #(
      .VISIBLE_WIDTH (W), .VISIBLE_HEIGHT (H), .FRAME_RATE (RATE),
      .TILE_W_LOG2 (TW), .TILE_H_LOG2 (TH), .BAR_W_LOG2 (BW),
      .INVERT_EN (1'b1), .SOLID_COLOR (SOLID)
   ) dut_a (
      .clock (clock), .reset (reset), .Mode (mode), .VideoReady (ready),
      .VideoValid (valid_a), .Video (video_a),
      .StartOfFrame (sof_a), .EndOfLine (eol_a)
   );

   pattern_generator_multi #(
      .VISIBLE_WIDTH (W), .VISIBLE_HEIGHT (H), .FRAME_RATE (RATE),
      .TILE_W_LOG2 (TW), .TILE_H_LOG2 (TH), .BAR_W_LOG2 (BW),
      .INVERT_EN (1'b0), .SOLID_COLOR (SOLID)
   ) dut_b (
      .clock (clock), .reset (reset), .Mode (mode), .VideoReady (ready),
      .VideoValid (valid_b), .Video (video_b),
      .StartOfFrame (sof_b), .EndOfLine (eol_b)
   );

   task automatic check(input string tag, input logic [23:0] got,
                        input logic [23:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %h expected %h (pixel %0d)", tag, got, exp, n);
      end
   endtask

   function automatic logic [23:0] ref_pix(input int md, input int px,
                                           input int py, input bit inv);
      logic [23:0] quad [4];
      logic [23:0] bars [8];
      logic [23:0] c;
      int          g;
      quad = '{24'h00CC00, 24'h00CCCC, 24'hFF9A26, 24'h9D26FF};
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      g = px % 256;
      case (md)
         0:       c = quad[((py / (1 << TH)) % 2) * 2 + (px / (1 << TW)) % 2];
         1:       c = bars[(px / (1 << BW)) % 8];
         2:       c = {g[7:0], g[7:0], g[7:0]};
         default: c = SOLID;
      endcase
      return inv ? ~c : c;
   endfunction

   task automatic cycle(input logic rdy, input logic [1:0] md, input logic rst);
      logic        acc, stall;
      logic [23:0] pv;
      logic        ps, pe;
      int          px, py, fr;
      bit          inv;
      ready = rdy;
      mode  = md;
      reset = rst;
      acc   = valid_a & rdy & ~rst;
      stall = valid_a & ~rdy & ~rst;
      pv    = video_a;
      ps    = sof_a;
      pe    = eol_a;
      if (acc && sof_a) begin
         if (have_sof) check("frame_len", 24'(n - sof_n), 24'(FP));
         have_sof = 1'b1;
         sof_n    = n;
      end
      @(posedge clock);
      if (rst) begin
         n        = 0;
         mmode    = md;
         have_sof = 1'b0;
      end else if (acc) begin
         if (n % FP == FP - 1) mmode = md;
         n++;
      end
      mvalid = ~rst;
      @(negedge clock);
      px  = int'(n % W);
      py  = int'((n / W) % H);
      fr  = int'(n / FP);
      inv = ((fr / RATE) % 2) == 1;
      check("valid_a", 24'(valid_a), 24'(mvalid));
      check("valid_b", 24'(valid_b), 24'(mvalid));
      check("video_a", video_a, ref_pix(mmode, px, py, inv));
      check("video_b", video_b, ref_pix(mmode, px, py, 1'b0));
      check("sof", 24'(sof_a), 24'(px == 0 && py == 0));
      check("eol", 24'(eol_a), 24'(px == W - 1));
      if (stall) begin
         check("stall_video", video_a, pv);
         check("stall_sof", 24'(sof_a), 24'(ps));
         check("stall_eol", 24'(eol_a), 24'(pe));
      end
      if (rst) begin
         check("rst_valid", 24'(valid_a), 24'd0);
         check("rst_sof", 24'(sof_a), 24'd1);
      end
      if (scripted && valid_a) begin
         if (fr == 0 && px == 0 && py == 0) check("quad_q1", video_a, 24'h00CC00);
         if (fr == 0 && px == 16 && py == 0) check("quad_q2", video_a, 24'h00CCCC);
         if (fr == 0 && px == 0 && py == 2) check("quad_q3", video_a, 24'hFF9A26);
         if (fr == 0 && px == 16 && py == 2) check("quad_q4", video_a, 24'h9D26FF);
         if (fr == 1 && px == 0) check("bar_white", video_a, 24'hFFFFFF);
         if (fr == 1 && px == 8) check("bar_yellow", video_a, 24'hFFFF00);
         if (fr == 1 && px == 120) check("bar_wrap7", video_a, 24'h000000);
         if (fr == 1 && px == 64) check("bar_wrap0", video_a, 24'hFFFFFF);
         if (fr == 2 && px == 44) check("ramp_44", video_a, 24'h2C2C2C);
         if (fr == 2 && px == 256) check("ramp_wrap", video_a, 24'h000000);
         if (fr == 3 && n % FP == 0) begin
            check("inv_on_a", video_a, 24'hFF33FF);
            check("inv_off_b", video_b, 24'h00CC00);
         end
         if (fr == 4 && px == 20 && py == 2) check("mid_chg_quad", video_b, 24'h9D26FF);
         if (fr == 5 && n % FP == 0) begin
            check("solid_a", video_a, 24'h7F7F7F);
            check("solid_b", video_b, 24'h808080);
         end
         if (fr == 6 && n % FP == 0) check("inv_back", video_a, 24'h00CC00);
      end
   endtask

   function automatic logic [1:0] script_mode(input int unsigned k);
      int unsigned f, p;
      f = k / FP;
      p = k % FP;
      case (f)
         0:       return 2'd1;
         1:       return 2'd2;
         4:       return (p >= W + 10) ? 2'd3 : 2'd0;
         default: return 2'd0;
      endcase
   endfunction

   initial begin
      int guard;
      @(negedge clock);
      cycle(1'b0, 2'd0, 1'b1);
      cycle(1'b0, 2'd0, 1'b1);

      scripted = 1'b1;
      guard    = 0;
      while (n < 6 * FP + 2 && guard < 8 * FP) begin
         cycle(1'b1, script_mode(n), 1'b0);
         guard++;
      end
      if (guard >= 8 * FP) check("script_timeout", 24'(n), 24'(6 * FP + 2));
      scripted = 1'b0;

      for (int i = 0; i < 2500; i++) begin
         cycle($urandom_range(0, 9) < 3, 2'($urandom), 1'b0);
      end

      guard = 0;
      while (n % FP != 2 * W + 150 && guard < 2 * FP) begin
         cycle(1'b1, 2'd2, 1'b0);
         guard++;
      end
      if (guard >= 2 * FP) check("seek_timeout", 24'(n % FP), 24'(2 * W + 150));
      cycle(1'b1, 2'd1, 1'b1);
      check("rst_bar_white", video_a, 24'hFFFFFF);

      for (int i = 0; i < 2 * FP; i++) begin
         cycle($urandom_range(0, 9) < 3, 2'($urandom), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
